// File: rtl/dso_cap_pkg.sv
// Shared types and constants for the DSO trigger/capture sequencer.
package dso_cap_pkg;

    localparam int CAP_AW = 9;

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} cap_state_e;

    localparam logic [1:0] TRIG_OFF  = 2'b00;
    localparam logic [1:0] TRIG_NORM = 2'b01;
    localparam logic [1:0] TRIG_AUTO = 2'b10;

    localparam logic [1:0] TRIG_SRC_1 = 2'b00;
    localparam logic [1:0] TRIG_SRC_2 = 2'b01;

    // Normal and auto are the only trigger types that allow a capture to run.
    function automatic logic trig_active(input logic [1:0] t);
        return (t == TRIG_NORM) || (t == TRIG_AUTO);
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// Two-flop synchronizer for one raw trigger comparator plus an edge flop;
// emits a one-clk pulse on the selected edge (rise_sel_i=1 rising, 0 falling).
module trig_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_i,
    input  logic rise_sel_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_o = rise_sel_i ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);

endmodule

// File: rtl/trig_capture_ctrl.sv
// Trigger detection and capture sequencing: decimate, pre-fill, arm, trigger, post-fill, done.
// Optional AUTO_TRIG_EN macro enables the auto-mode timeout trigger.
module trig_capture_ctrl
    import dso_cap_pkg::*;
#(
    parameter int AW      = CAP_AW,
    parameter int AUTO_TO = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          smpl_vld,
    input  logic          trig1,
    input  logic          trig2,
    input  logic          trig_edge,
    input  logic [1:0]    trig_type,
    input  logic [1:0]    trig_src,
    input  logic [AW-1:0] trig_pos,
    input  logic [3:0]    decimator,
    input  logic          clr_cap_done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [AW-1:0] trace_end,
    output logic          cap_done,
    output logic          armed,
    output logic          auto_trig
);

    localparam int DEPTH = 2**AW;
    localparam int ATW   = $clog2(AUTO_TO + 1);

`ifdef AUTO_TRIG_EN
    localparam logic AUTO_EN = 1'b1;
`else
    localparam logic AUTO_EN = 1'b0;
`endif

    cap_state_e    state_q, state_d;
    logic [AW-1:0] pos_q, pos_d;
    logic [3:0]    dec_sel_q, dec_sel_d;
    logic [1:0]    src_q, src_d;
    logic [1:0]    type_q, type_d;
    logic          edge_sel_q, edge_sel_d;
    logic [14:0]   dec_cnt_q, dec_cnt_d;
    logic [AW-1:0] pre_cnt_q, pre_cnt_d;
    logic [AW:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [ATW-1:0] auto_cnt_q, auto_cnt_d;
    logic          pend_q, pend_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] trace_end_q, trace_end_d;
    logic          cap_done_q, cap_done_d;
    logic          auto_trig_q, auto_trig_d;

    logic [1:0]    trig_raw;
    logic [1:0]    edge_vec;
    logic          edge_hit;
    logic [14:0]   dec_max;
    logic          slot;
    logic [AW:0]   post_target;

    assign trig_raw = {trig2, trig1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        trig_edge_det u_det (
            .clk       (clk),
            .rst_n     (rst_n),
            .trig_i    (trig_raw[gi]),
            .rise_sel_i(edge_sel_q),
            .edge_o    (edge_vec[gi])
        );
    end

    assign edge_hit    = (src_q == TRIG_SRC_1) ? edge_vec[0] :
                         (src_q == TRIG_SRC_2) ? edge_vec[1] : 1'b0;
    assign dec_max     = 15'((16'd1 << dec_sel_q) - 16'd1);
    assign slot        = smpl_vld && (dec_cnt_q == '0);
    assign post_target = (AW+1)'(DEPTH) - (AW+1)'(pos_q);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dec_sel_d   = dec_sel_q;
        src_d       = src_q;
        type_d      = type_q;
        edge_sel_d  = edge_sel_q;
        dec_cnt_d   = dec_cnt_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        auto_cnt_d  = auto_cnt_q;
        pend_d      = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        trace_end_d = trace_end_q;
        cap_done_d  = cap_done_q;
        auto_trig_d = auto_trig_q;

        if (clr_cap_done) cap_done_d = 1'b0;
        if ((state_q inside {PRE, WAIT, POST}) && smpl_vld)
            dec_cnt_d = (dec_cnt_q == dec_max) ? '0 : dec_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                dec_cnt_d = '0;
                if (trig_active(trig_type) && !cap_done_q) begin
                    state_d     = PRE;
                    pos_d       = trig_pos;
                    dec_sel_d   = decimator;
                    src_d       = trig_src;
                    type_d      = trig_type;
                    edge_sel_d  = trig_edge;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    wr_ptr_d    = '0;
                    auto_cnt_d  = '0;
                    auto_trig_d = 1'b0;
                end
            end
            PRE: begin
                if (pos_q == '0) begin
                    state_d = WAIT;
                end else if (slot) begin
                    we_d      = 1'b1;
                    addr_d    = wr_ptr_q;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_d == pos_q) state_d = WAIT;
                end
            end
            WAIT: begin
                // Edges landing between decimated slots are held until the next slot.
                pend_d = pend_q | edge_hit;
                if (slot) begin
                    we_d     = 1'b1;
                    addr_d   = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (pend_q || edge_hit ||
                        (AUTO_EN && type_q == TRIG_AUTO && auto_cnt_q == ATW'(AUTO_TO))) begin
                        auto_trig_d = !(pend_q || edge_hit);
                        pend_d      = 1'b0;
                        post_cnt_d  = (AW+1)'(1);
                        state_d     = (post_target == (AW+1)'(1)) ? DONE : POST;
                    end else if (auto_cnt_q != ATW'(AUTO_TO)) begin
                        auto_cnt_d = auto_cnt_q + 1'b1;
                    end
                end
            end
            POST: begin
                if (slot) begin
                    we_d       = 1'b1;
                    addr_d     = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (post_cnt_d == post_target) state_d = DONE;
                end
            end
            DONE: begin
                cap_done_d  = 1'b1;
                trace_end_d = addr_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Turning the trigger off abandons any capture that has not yet completed.
        if (state_q != DONE && !trig_active(trig_type)) begin
            state_d = IDLE;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            dec_sel_q   <= '0;
            src_q       <= '0;
            type_q      <= '0;
            edge_sel_q  <= 1'b0;
            dec_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            auto_cnt_q  <= '0;
            pend_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            trace_end_q <= '0;
            cap_done_q  <= 1'b0;
            auto_trig_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dec_sel_q   <= dec_sel_d;
            src_q       <= src_d;
            type_q      <= type_d;
            edge_sel_q  <= edge_sel_d;
            dec_cnt_q   <= dec_cnt_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            auto_cnt_q  <= auto_cnt_d;
            pend_q      <= pend_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            trace_end_q <= trace_end_d;
            cap_done_q  <= cap_done_d;
            auto_trig_q <= auto_trig_d;
        end
    end

    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign trace_end = trace_end_q;
    assign cap_done  = cap_done_q;
    assign armed     = (state_q == WAIT);
    assign auto_trig = auto_trig_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl: pre/post fill, decimation, edge qualification,
// done/clear priority, abort, auto mode (AUTO_TRIG_EN) and reset.
module tb_trig_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       smpl_vld;
    logic       trig1;
    logic       trig2;
    logic       trig_edge;
    logic [1:0] trig_type;
    logic [1:0] trig_src;
    logic [8:0] trig_pos;
    logic [3:0] decimator;
    logic       clr_cap_done;
    logic       ram_we;
    logic [8:0] ram_addr;
    logic [8:0] trace_end;
    logic       cap_done;
    logic       armed;
    logic       auto_trig;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    int addr_bad = 0;
    int gap_bad = 0;
    int exp_gap = 0;
    int last_we_cyc = 0;
    logic [8:0] exp_addr = '0;

    trig_capture_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .smpl_vld    (smpl_vld),
        .trig1       (trig1),
        .trig2       (trig2),
        .trig_edge   (trig_edge),
        .trig_type   (trig_type),
        .trig_src    (trig_src),
        .trig_pos    (trig_pos),
        .decimator   (decimator),
        .clr_cap_done(clr_cap_done),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .trace_end   (trace_end),
        .cap_done    (cap_done),
        .armed       (armed),
        .auto_trig   (auto_trig)
    );

    always #5 clk = ~clk;

    initial begin
        #600us;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1, "timeout");
    end

    // Advance to the next falling edge and record any RAM write seen there.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ram_we === 1'b1) begin
            if (ram_addr !== exp_addr) addr_bad++;
            if (exp_gap != 0 && we_cnt != 0 && (cyc - last_we_cyc) != exp_gap) gap_bad++;
            last_we_cyc = cyc;
            we_cnt++;
            exp_addr++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic begin_cap();
        exp_addr = '0;
        we_cnt   = 0;
        addr_bad = 0;
        gap_bad  = 0;
    endtask

    task automatic start(input logic [8:0] pos, input logic [3:0] dec, input logic [1:0] src,
                         input logic edg, input logic [1:0] typ);
        trig_pos  = pos;
        decimator = dec;
        trig_src  = src;
        trig_edge = edg;
        trig_type = typ;
        tick();
    endtask

    task automatic clear_done();
        trig_type    = 2'b00;
        clr_cap_done = 1'b1;
        tick();
        clr_cap_done = 1'b0;
        tick();
    endtask

    task automatic samp();
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        ticks(3);
    endtask

    task automatic samps(input int n);
        for (int i = 0; i < n; i++) samp();
    endtask

    initial begin
        rst_n = 1'b0; smpl_vld = 1'b0; trig1 = 1'b0; trig2 = 1'b0; trig_edge = 1'b1;
        trig_type = 2'b00; trig_src = 2'b00; trig_pos = '0; decimator = '0; clr_cap_done = 1'b0;
        ticks(3);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_trace_end", 32'(trace_end), 0);
        chk("rst_cap_done", 32'(cap_done), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_auto_trig", 32'(auto_trig), 0);
        rst_n = 1'b1;
        ticks(2);

        // 1: 0x134 pre samples, trigger on sample 400 at addr 399, 0xCC post
        begin_cap();
        start(9'h134, 4'd0, 2'b00, 1'b1, 2'b01);
        samps(307);
        chk("t1_armed_pre", 32'(armed), 0);
        samp();
        chk("t1_armed", 32'(armed), 1);
        samps(91);
        trig1 = 1'b1;
        ticks(4);
        samp();
        chk("t1_post_unarmed", 32'(armed), 0);
        samps(203);
        ticks(3);
        chk("t1_cap_done", 32'(cap_done), 1);
        chk("t1_trace_end", 32'(trace_end), 90);
        chk("t1_writes", 32'(we_cnt), 603);
        chk("t1_addr_seq", 32'(addr_bad), 0);

        // 2: decimate by 4 with continuous samples
        clear_done();
        trig1 = 1'b0;
        ticks(4);
        begin_cap();
        exp_gap = 4;
        trig_pos = '0; decimator = 4'd2; trig_src = 2'b00; trig_edge = 1'b1;
        trig_type = 2'b01; trig1 = 1'b1; smpl_vld = 1'b1;
        for (int i = 0; i < 3000 && cap_done !== 1'b1; i++) tick();
        smpl_vld = 1'b0;
        exp_gap = 0;
        chk("t2_cap_done", 32'(cap_done), 1);
        chk("t2_writes", 32'(we_cnt), 512);
        chk("t2_gap", 32'(gap_bad), 0);
        chk("t2_trace_end", 32'(trace_end), 511);
        chk("t2_addr_seq", 32'(addr_bad), 0);

        // 3: trig_pos=0, falling edge on trig2
        clear_done();
        trig1 = 1'b0;
        trig2 = 1'b1;
        ticks(4);
        begin_cap();
        start(9'd0, 4'd0, 2'b01, 1'b0, 2'b01);
        chk("t3_armed_pre", 32'(armed), 0);
        tick();
        chk("t3_armed", 32'(armed), 1);
        trig2 = 1'b0;
        ticks(4);
        samps(512);
        ticks(3);
        chk("t3_cap_done", 32'(cap_done), 1);
        chk("t3_writes", 32'(we_cnt), 512);
        chk("t3_trace_end", 32'(trace_end), 511);
        chk("t3_addr_seq", 32'(addr_bad), 0);

        // 4: PRE edge ignored, wrong-polarity edge ignored, next rising edge taken
        clear_done();
        begin_cap();
        start(9'd4, 4'd0, 2'b00, 1'b1, 2'b01);
        samps(2);
        trig1 = 1'b1;
        ticks(4);
        samps(2);
        chk("t4_armed", 32'(armed), 1);
        trig1 = 1'b0;
        ticks(4);
        samp();
        chk("t4_fall_ignored", 32'(armed), 1);
        chk("t4_wait_writes", 32'(we_cnt), 5);
        trig1 = 1'b1;
        ticks(4);
        samp();
        chk("t4_triggered", 32'(armed), 0);
        samps(506);
        // 6: clear in the same clk as the done set
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        clr_cap_done = 1'b1;
        tick();
        clr_cap_done = 1'b0;
        chk("t6_done_priority", 32'(cap_done), 1);
        tick();
        chk("t6_done_held", 32'(cap_done), 1);
        chk("t4_trace_end", 32'(trace_end), 0);
        chk("t4_writes", 32'(we_cnt), 513);
        chk("t4_addr_seq", 32'(addr_bad), 0);
        clear_done();
        chk("t6_cleared", 32'(cap_done), 0);

        // 6: abort from POST
        trig1 = 1'b0;
        ticks(4);
        begin_cap();
        start(9'd2, 4'd0, 2'b00, 1'b1, 2'b01);
        samps(2);
        trig1 = 1'b1;
        ticks(4);
        samps(2);
        chk("t6_post_writes", 32'(we_cnt), 4);
        trig_type = 2'b00;
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        chk("t6_abort_we", 32'(ram_we), 0);
        chk("t6_abort_armed", 32'(armed), 0);
        ticks(3);
        chk("t6_abort_writes", 32'(we_cnt), 4);
        chk("t6_abort_done", 32'(cap_done), 0);
        trig1 = 1'b0;
        ticks(4);

        // 5: auto mode, no edges
        begin_cap();
        start(9'd0, 4'd0, 2'b00, 1'b1, 2'b10);
        smpl_vld = 1'b1;
`ifdef AUTO_TRIG_EN
        for (int i = 0; i < 6000 && cap_done !== 1'b1; i++) tick();
        smpl_vld = 1'b0;
        ticks(2);
        chk("t5_cap_done", 32'(cap_done), 1);
        chk("t5_auto_trig", 32'(auto_trig), 1);
        chk("t5_writes", 32'(we_cnt), 4608);
        chk("t5_trace_end", 32'(trace_end), 511);
        clear_done();
        start(9'd0, 4'd0, 2'b00, 1'b1, 2'b01);
        chk("t5_auto_cleared", 32'(auto_trig), 0);
        tick();
`else
        ticks(4300);
        chk("t5_no_capture", 32'(cap_done), 0);
        chk("t5_still_armed", 32'(armed), 1);
        chk("t5_auto_trig", 32'(auto_trig), 0);
        chk("t5_addr_seq", 32'(addr_bad), 0);
`endif
        chk("t5_armed_before_rst", 32'(armed), 1);
        rst_n = 1'b0;
        tick();
        smpl_vld = 1'b0;
        chk("rst_mid_armed", 32'(armed), 0);
        chk("rst_mid_we", 32'(ram_we), 0);
        rst_n = 1'b1;
        trig_type = 2'b00;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
